// File: rtl/phy_ctrl_pkg.sv
// Shared types and constants for the PHY link sequencer.
// FSM encoding, speed codes and PHY register/bit defaults.
package phy_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST_REQ,
        ST_HOST_WAIT,
        ST_STAT_REQ,
        ST_STAT_WAIT,
        ST_SPEC_REQ,
        ST_SPEC_WAIT,
        ST_UPDATE
    } state_e;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam logic [4:0] STAT_REG_DEF = 5'd1;
    localparam logic [4:0] SPEC_REG_DEF = 5'd17;

    localparam int LINK_BIT   = 2;
    localparam int SPEED_MSB  = 15;
    localparam int SPEED_LSB  = 14;
    localparam int DUPLEX_BIT = 13;

endpackage

// File: rtl/phy_poll_timer.sv
// Poll interval down-counter with a single pending flag.
// Expiries while a poll is still pending are absorbed.
module phy_poll_timer #(
    parameter int unsigned POLL_PERIOD = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_poll_en,
    input  logic i_poll_ack,
    output logic o_poll_pend
);

    localparam int unsigned CW = $clog2(POLL_PERIOD);
    localparam logic [CW-1:0] RELOAD = CW'(POLL_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          expire;

    assign expire      = i_poll_en && (cnt_q == '0);
    assign o_poll_pend = pend_q;

    // Count down while enabled, hold at reload when disabled.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (!i_poll_en) begin
            cnt_d = RELOAD;
        end else if (expire) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        if (i_poll_ack) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end
    end

    // Counter and pending flag registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q  <= RELOAD;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/phy_link_ctrl.sv
// PHY access arbiter: periodic link/speed/duplex poll plus host access.
// Optional PHY_LINK_IRQ_EN adds a sticky link-change interrupt.
module phy_link_ctrl
    import phy_ctrl_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 1000000,
    parameter logic [4:0]  STAT_REG    = STAT_REG_DEF,
    parameter logic [4:0]  SPEC_REG    = SPEC_REG_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_poll_en,
    input  logic        i_host_request,
    input  logic        i_host_rdwn,
    input  logic [4:0]  i_host_addr,
    input  logic [31:0] i_host_wr_data,
    output logic        o_host_busy,
    output logic        o_host_done,
    output logic [31:0] o_host_rd_data,
    output logic        o_phy_request,
    output logic        o_phy_rdwn,
    output logic [4:0]  o_phy_addr,
    output logic [31:0] o_phy_wr_data,
    input  logic        i_phy_done,
    input  logic [31:0] i_phy_rd_data,
    output logic        o_link_up,
    output logic [1:0]  o_speed,
    output logic        o_full_duplex,
    output logic        o_link_change
`ifdef PHY_LINK_IRQ_EN
    ,
    input  logic        i_irq_clr,
    output logic        o_irq
`endif
);

    state_e      state_q, state_d;
    logic        host_pend_q, host_pend_d;
    logic        host_rdwn_q, host_rdwn_d;
    logic [4:0]  host_addr_q, host_addr_d;
    logic [31:0] host_wr_q, host_wr_d;
    logic        host_done_q, host_done_d;
    logic [31:0] host_rd_q, host_rd_d;
    logic        phy_req_q, phy_req_d;
    logic        phy_rdwn_q, phy_rdwn_d;
    logic [4:0]  phy_addr_q, phy_addr_d;
    logic [31:0] phy_wr_q, phy_wr_d;
    logic        link_cap_q, link_cap_d;
    logic [1:0]  speed_cap_q, speed_cap_d;
    logic        dup_cap_q, dup_cap_d;
    logic        link_up_q, link_up_d;
    logic [1:0]  speed_q, speed_d;
    logic        duplex_q, duplex_d;
    logic        change_q, change_d;
    logic        poll_pend;
    logic        poll_ack;

    phy_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_poll_en   (i_poll_en),
        .i_poll_ack  (poll_ack),
        .o_poll_pend (poll_pend)
    );

    assign o_host_busy    = host_pend_q;
    assign o_host_done    = host_done_q;
    assign o_host_rd_data = host_rd_q;
    assign o_phy_request  = phy_req_q;
    assign o_phy_rdwn     = phy_rdwn_q;
    assign o_phy_addr     = phy_addr_q;
    assign o_phy_wr_data  = phy_wr_q;
    assign o_link_up      = link_up_q;
    assign o_speed        = speed_q;
    assign o_full_duplex  = duplex_q;
    assign o_link_change  = change_q;

    // Host capture, arbitration and the poll sequence.
    always_comb begin
        state_d     = state_q;
        host_pend_d = host_pend_q;
        host_rdwn_d = host_rdwn_q;
        host_addr_d = host_addr_q;
        host_wr_d   = host_wr_q;
        host_done_d = 1'b0;
        host_rd_d   = '0;
        phy_req_d   = 1'b0;
        phy_rdwn_d  = phy_rdwn_q;
        phy_addr_d  = phy_addr_q;
        phy_wr_d    = phy_wr_q;
        link_cap_d  = link_cap_q;
        speed_cap_d = speed_cap_q;
        dup_cap_d   = dup_cap_q;
        link_up_d   = link_up_q;
        speed_d     = speed_q;
        duplex_d    = duplex_q;
        change_d    = 1'b0;
        poll_ack    = 1'b0;

        if (i_host_request && !host_pend_q) begin
            host_pend_d = 1'b1;
            host_rdwn_d = i_host_rdwn;
            host_addr_d = i_host_addr;
            host_wr_d   = i_host_wr_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (host_pend_q) begin
                    state_d = ST_HOST_REQ;
                end else if (poll_pend) begin
                    state_d = ST_STAT_REQ;
                end
            end
            ST_HOST_REQ: begin
                phy_req_d  = 1'b1;
                phy_rdwn_d = host_rdwn_q;
                phy_addr_d = host_addr_q;
                phy_wr_d   = host_wr_q;
                state_d    = ST_HOST_WAIT;
            end
            ST_HOST_WAIT: begin
                if (i_phy_done) begin
                    host_done_d = 1'b1;
                    host_rd_d   = host_rdwn_q ? i_phy_rd_data : '0;
                    host_pend_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_STAT_REQ: begin
                phy_req_d  = 1'b1;
                phy_rdwn_d = 1'b1;
                phy_addr_d = STAT_REG;
                phy_wr_d   = '0;
                state_d    = ST_STAT_WAIT;
            end
            ST_STAT_WAIT: begin
                if (i_phy_done) begin
                    link_cap_d = i_phy_rd_data[LINK_BIT];
                    poll_ack   = 1'b1;
                    state_d    = i_phy_rd_data[LINK_BIT] ? ST_SPEC_REQ
                                                         : ST_UPDATE;
                end
            end
            ST_SPEC_REQ: begin
                phy_req_d  = 1'b1;
                phy_rdwn_d = 1'b1;
                phy_addr_d = SPEC_REG;
                phy_wr_d   = '0;
                state_d    = ST_SPEC_WAIT;
            end
            ST_SPEC_WAIT: begin
                if (i_phy_done) begin
                    speed_cap_d = i_phy_rd_data[SPEED_MSB:SPEED_LSB];
                    dup_cap_d   = i_phy_rd_data[DUPLEX_BIT];
                    state_d     = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                link_up_d = link_cap_q;
                if (link_cap_q) begin
                    speed_d  = speed_cap_q;
                    duplex_d = dup_cap_q;
                end
                change_d = (link_up_d != link_up_q) ||
                           (speed_d != speed_q) ||
                           (duplex_d != duplex_q);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            host_pend_q <= 1'b0;
            host_rdwn_q <= 1'b0;
            host_addr_q <= '0;
            host_wr_q   <= '0;
            host_done_q <= 1'b0;
            host_rd_q   <= '0;
            phy_req_q   <= 1'b0;
            phy_rdwn_q  <= 1'b0;
            phy_addr_q  <= '0;
            phy_wr_q    <= '0;
            link_cap_q  <= 1'b0;
            speed_cap_q <= SPEED_10;
            dup_cap_q   <= 1'b0;
            link_up_q   <= 1'b0;
            speed_q     <= SPEED_10;
            duplex_q    <= 1'b0;
            change_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            host_pend_q <= host_pend_d;
            host_rdwn_q <= host_rdwn_d;
            host_addr_q <= host_addr_d;
            host_wr_q   <= host_wr_d;
            host_done_q <= host_done_d;
            host_rd_q   <= host_rd_d;
            phy_req_q   <= phy_req_d;
            phy_rdwn_q  <= phy_rdwn_d;
            phy_addr_q  <= phy_addr_d;
            phy_wr_q    <= phy_wr_d;
            link_cap_q  <= link_cap_d;
            speed_cap_q <= speed_cap_d;
            dup_cap_q   <= dup_cap_d;
            link_up_q   <= link_up_d;
            speed_q     <= speed_d;
            duplex_q    <= duplex_d;
            change_q    <= change_d;
        end
    end

`ifdef PHY_LINK_IRQ_EN
    logic irq_q, irq_d;

    assign o_irq = irq_q;

    // Sticky interrupt: a new link change outranks a clear.
    always_comb begin
        irq_d = irq_q;
        if (i_irq_clr) begin
            irq_d = 1'b0;
        end
        if (change_q) begin
            irq_d = 1'b1;
        end
    end

    // Interrupt level register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Bench for phy_link_ctrl: PHY access-block model, link-state model
// checked every cycle, and directed scenarios with literal expectations.
module tb_phy_link_ctrl;

    localparam int PP = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        poll_en;
    logic        host_req;
    logic        host_rdwn;
    logic [4:0]  host_addr;
    logic [31:0] host_wr;
    logic        host_busy;
    logic        host_done;
    logic [31:0] host_rd;
    logic        phy_req;
    logic        phy_rdwn;
    logic [4:0]  phy_addr;
    logic [31:0] phy_wr;
    logic        phy_done;
    logic [31:0] phy_rd;
    logic        link_up;
    logic [1:0]  speed;
    logic        duplex;
    logic        link_chg;
`ifdef PHY_LINK_IRQ_EN
    logic        irq_clr;
    logic        irq;
`endif

    phy_link_ctrl #(
        .POLL_PERIOD (PP)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_poll_en      (poll_en),
        .i_host_request (host_req),
        .i_host_rdwn    (host_rdwn),
        .i_host_addr    (host_addr),
        .i_host_wr_data (host_wr),
        .o_host_busy    (host_busy),
        .o_host_done    (host_done),
        .o_host_rd_data (host_rd),
        .o_phy_request  (phy_req),
        .o_phy_rdwn     (phy_rdwn),
        .o_phy_addr     (phy_addr),
        .o_phy_wr_data  (phy_wr),
        .i_phy_done     (phy_done),
        .i_phy_rd_data  (phy_rd),
        .o_link_up      (link_up),
        .o_speed        (speed),
        .o_full_duplex  (duplex),
        .o_link_change  (link_chg)
`ifdef PHY_LINK_IRQ_EN
        ,
        .i_irq_clr      (irq_clr),
        .o_irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // PHY register file and access-block state
    logic [31:0] mem [32];
    int          lat = 5;
    bit          fl_act = 0;
    int          fl_cnt = 0;
    logic [4:0]  fl_addr;
    logic        fl_rdwn;
    logic [31:0] fl_wr;
    logic [4:0]  lg_addr [64];
    logic        lg_rdwn [64];
    logic [31:0] lg_wr [64];
    int          lg_cyc [64];
    int          nlog = 0;

    // Expected link state
    bit          armed = 0;
    bit          rst_seen = 0;
    logic        exp_link = 0;
    logic [1:0]  exp_speed = 0;
    logic        exp_dup = 0;
    logic        exp_chg = 0;
    logic        new_link = 0;
    logic [1:0]  new_speed = 0;
    logic        new_dup = 0;
    int          upd_cnt = 0;
    int          hd_cnt = 0;
    logic [31:0] hd_val = 0;
    logic        exp_hdone = 0;
    logic [31:0] exp_hdata = 0;
    logic        exp_irq = 0;
    logic        prev_chg = 0;
    logic        prev_clr = 0;

    // Model and compare process; runs on the falling edge.
    always @(negedge clk) begin
        exp_chg   = 1'b0;
        exp_hdone = 1'b0;
        exp_hdata = '0;
        if (prev_chg) exp_irq = 1'b1;
        else if (prev_clr) exp_irq = 1'b0;
        if (upd_cnt > 0) begin
            upd_cnt--;
            if (upd_cnt == 0) begin
                exp_chg = (new_link != exp_link) ||
                          (new_speed != exp_speed) ||
                          (new_dup != exp_dup);
                exp_link  = new_link;
                exp_speed = new_speed;
                exp_dup   = new_dup;
            end
        end
        if (hd_cnt > 0) begin
            hd_cnt--;
            if (hd_cnt == 0) begin
                exp_hdone = 1'b1;
                exp_hdata = hd_val;
            end
        end
        if (rst_seen) begin
            exp_link = 0; exp_speed = 0; exp_dup = 0; exp_chg = 0;
            exp_hdone = 0; exp_hdata = 0; exp_irq = 0;
            upd_cnt = 0; hd_cnt = 0;
            armed = 1;
        end
        if (armed) begin
            chk("link_up", link_up, exp_link);
            chk("speed", speed, exp_speed);
            chk("duplex", duplex, exp_dup);
            chk("link_change", link_chg, exp_chg);
            chk("host_done", host_done, exp_hdone);
            chk("host_rd_data", host_rd, exp_hdata);
`ifdef PHY_LINK_IRQ_EN
            chk("irq", irq, exp_irq);
`endif
            if (fl_act) chk("wr_data_hold", phy_wr, fl_wr);
        end
        rst_seen = !rst_n;
        prev_chg = exp_chg;
`ifdef PHY_LINK_IRQ_EN
        prev_clr = irq_clr;
`else
        prev_clr = 1'b0;
`endif
        phy_done = 1'b0;
        phy_rd   = '0;
        if (!rst_n) begin
            fl_act = 0;
        end else if (armed) begin
            if (fl_act) begin
                fl_cnt--;
                if (fl_cnt == 0) begin
                    fl_act   = 0;
                    phy_done = 1'b1;
                    if (fl_rdwn) phy_rd = mem[fl_addr];
                    else mem[fl_addr] = fl_wr;
                    if (fl_rdwn && fl_addr == 5'd1) begin
                        if (!phy_rd[2]) begin
                            new_link  = 1'b0;
                            new_speed = exp_speed;
                            new_dup   = exp_dup;
                            upd_cnt   = 2;
                        end
                    end else if (fl_rdwn && fl_addr == 5'd17) begin
                        new_link  = 1'b1;
                        new_speed = phy_rd[15:14];
                        new_dup   = phy_rd[13];
                        upd_cnt   = 2;
                    end else begin
                        hd_cnt = 1;
                        hd_val = fl_rdwn ? phy_rd : 32'h0;
                    end
                end
            end
            if (phy_req) begin
                chk("req_while_busy", {31'b0, fl_act}, 32'h0);
                fl_act  = 1;
                fl_cnt  = lat;
                fl_addr = phy_addr;
                fl_rdwn = phy_rdwn;
                fl_wr   = phy_wr;
                if (nlog < 64) begin
                    lg_addr[nlog] = phy_addr;
                    lg_rdwn[nlog] = phy_rdwn;
                    lg_wr[nlog]   = phy_wr;
                    lg_cyc[nlog]  = cyc;
                end
                nlog++;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic host(input logic rw, input logic [4:0] a,
                        input logic [31:0] d);
        host_rdwn = rw;
        host_addr = a;
        host_wr   = d;
        host_req  = 1'b1;
        step();
        host_req  = 1'b0;
    endtask

    task automatic wait_hdone(input int bound);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!host_done && n < bound);
        chk("host_done_wait", host_done, 1);
    endtask

    task automatic wait_lchg(input int bound);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!link_chg && n < bound);
        chk("link_change_wait", link_chg, 1);
    endtask

    int n0;
    int rq_cyc;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst_n     = 1'b0;
        poll_en   = 1'b0;
        host_req  = 1'b0;
        host_rdwn = 1'b0;
        host_addr = '0;
        host_wr   = '0;
        phy_done  = 1'b0;
        phy_rd    = '0;
`ifdef PHY_LINK_IRQ_EN
        irq_clr   = 1'b0;
`endif
        step(3);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_busy", host_busy, 0);
        chk("rst_phy_req", phy_req, 0);
        chk("rst_link", link_up, 0);
        chk("rst_speed", speed, 0);
        step(2);

        // host read, 5-cycle access latency
        mem[2] = 32'h0000_0141;
        lat    = 5;
        n0     = nlog;
        rq_cyc = cyc;
        host(1'b1, 5'd2, 32'h0);
        chk("busy_after_req", host_busy, 1);
        wait_hdone(40);
        chk("host_read_data", host_rd, 32'h141);
        chk("host_read_nreq", nlog - n0, 1);
        chk("host_read_addr", lg_addr[n0], 2);
        chk("host_read_rdwn", lg_rdwn[n0], 1);
        chk("turnaround", lg_cyc[n0] - rq_cyc, 3);
        step(3);
        chk("busy_cleared", host_busy, 0);

        // poll with link up, 1000M full duplex
        mem[1]  = 32'h0000_0004;
        mem[17] = 32'h0000_A000;
        n0      = nlog;
        poll_en = 1'b1;
        wait_lchg(100);
        poll_en = 1'b0;
        chk("up_link", link_up, 1);
        chk("up_speed", speed, 2'b10);
        chk("up_duplex", duplex, 1);
        chk("up_nacc", nlog - n0, 2);
        chk("up_stat_addr", lg_addr[n0], 1);
        chk("up_spec_addr", lg_addr[n0+1], 17);
        step(40);
`ifdef PHY_LINK_IRQ_EN
        chk("irq_set", irq, 1);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        step();
        chk("irq_cleared", irq, 0);
`endif

        // link down: one access, speed/duplex retained
        mem[1]  = 32'h0;
        n0      = nlog;
        poll_en = 1'b1;
        wait_lchg(100);
        poll_en = 1'b0;
        chk("down_link", link_up, 0);
        chk("down_speed", speed, 2'b10);
        chk("down_duplex", duplex, 1);
        chk("down_nacc", nlog - n0, 1);
        step(40);
`ifdef PHY_LINK_IRQ_EN
        chk("irq_set2", irq, 1);
`endif

        // host request on the same cycle the poll becomes pending
        lat     = 6;
        n0      = nlog;
        poll_en = 1'b1;
        step(PP - 1);
        host(1'b0, 5'd5, 32'h1234);
        poll_en = 1'b0;
        step(4);
        chk("coll_busy", host_busy, 1);
        host(1'b0, 5'd6, 32'h5678);
        step(60);
        chk("coll_nacc", nlog - n0, 2);
        chk("coll_first_addr", lg_addr[n0], 5);
        chk("coll_first_rdwn", lg_rdwn[n0], 0);
        chk("coll_first_wr", lg_wr[n0], 32'h1234);
        chk("coll_second_addr", lg_addr[n0+1], 1);
        chk("coll_second_rdwn", lg_rdwn[n0+1], 1);
        chk("coll_busy_end", host_busy, 0);

        // reset while the host access is in flight
        lat = 5;
        n0  = nlog;
        host(1'b1, 5'd2, 32'h0);
        for (int i = 0; i < 20 && nlog == n0; i++) begin
            @(negedge clk); #1;
        end
        chk("rst_req_seen", nlog - n0, 1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_busy", host_busy, 0);
        chk("mid_rst_done", host_done, 0);
        chk("mid_rst_req", phy_req, 0);
        chk("mid_rst_addr", phy_addr, 0);
        chk("mid_rst_rdwn", phy_rdwn, 0);
        chk("mid_rst_link", link_up, 0);
        chk("mid_rst_speed", speed, 0);
        chk("mid_rst_dup", duplex, 0);
        step(20);
        chk("post_rst_busy", host_busy, 0);
        chk("post_rst_nacc", nlog - n0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
